// File: rtl/fs_serial_pkg.sv
// -----------------------------------------------------------------------------
// fs_serial_pkg
//
// Shared definitions for the bit-serial full subtractor:
//   - FS_WIDTH_DEFAULT : default operand/result width
//   - FS_IDLE/RUN/DONE : FSM state encodings (2-bit, legacy-compatible values)
//   - fs_cnt_width()   : bit-counter width for a given operand width
// -----------------------------------------------------------------------------
package fs_serial_pkg;

  localparam int FS_WIDTH_DEFAULT = 8;

  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_RUN  = 2'd1;
  localparam logic [1:0] FS_DONE = 2'd2;

  // The counter only has to index bits 0..width-1; the terminal count is
  // width-1, so clog2(width) bits always suffice and the wrap is never used.
  function automatic int fs_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage : fs_serial_pkg

// File: rtl/fs_cell.sv
// -----------------------------------------------------------------------------
// fs_cell
//
// Purely combinational 1-bit full subtractor: d = a - b - bin.
//
// Ports:
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow-in
//   d    out 1  difference bit
//   bout out 1  borrow-out (1 when a < b + bin)
// -----------------------------------------------------------------------------
module fs_cell (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;

  // A borrow is generated when a=0,b=1, and propagated when a==b and a
  // borrow is already pending.
  assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule : fs_cell

// File: rtl/fs_serial.sv
// -----------------------------------------------------------------------------
// fs_serial
//
// Bit-serial WIDTH-bit full subtractor. Computes d = a - b - bin one bit per
// clock, LSB first, through a single fs_cell and a borrow flip-flop. Each
// operation is framed by a start/busy/done handshake:
//   IDLE : waits for start; on start captures a, b, bin.
//   RUN  : processes one bit per edge for WIDTH edges.
//   DONE : one-cycle done pulse with d/bout valid; start here is accepted
//          exactly as in IDLE, giving one result per WIDTH+1 cycles.
//
// Parameters:
//   WIDTH  operand and result width in bits (>= 2)
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only while busy = 0
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow-in, captured on accepted start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, d/bout valid in that cycle
//   d      out  WIDTH  difference, (a - b - bin) mod 2^WIDTH
//   bout   out  1      borrow-out, 1 iff a < b + bin (unsigned)
//
// All outputs come straight from flops; nothing combinational reaches them
// from the inputs. d and bout hold their last result in IDLE and are not
// meaningful while busy is high.
// -----------------------------------------------------------------------------
module fs_serial
  import fs_serial_pkg::*;
#(
  parameter int WIDTH = FS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int             CW       = fs_cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q;
  logic [1:0]       state_n;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr;      // minuend, shifted right so bit i sits at [0]
  logic [WIDTH-1:0] b_sr;      // subtrahend, same alignment as a_sr
  logic [WIDTH-1:0] d_q;       // result, filled from the MSB end
  logic             br_q;      // running borrow between bit positions
  logic             bout_q;    // final borrow, held with the result
  logic             busy_q;
  logic             done_q;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic in_run;
  logic accept;
  logic last_bit;

  assign in_run   = (state_q == FS_RUN);
  // start is honoured in IDLE and in the DONE cycle, never while running.
  assign accept   = start && ((state_q == FS_IDLE) || (state_q == FS_DONE));
  assign last_bit = in_run && (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Single subtractor cell, fed from the low end of the operand shifters.
  // ---------------------------------------------------------------------------
  logic cell_d;
  logic cell_bout;

  fs_cell u_cell (
    .d    (cell_d),
    .bout (cell_bout),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br_q)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assigning a default before the case means every path drives
    // state_n, so no latch is inferred for unlisted states or conditions.
    state_n = state_q;
    case (state_q)
      FS_IDLE: begin
        if (accept) state_n = FS_RUN;
      end
      FS_RUN: begin
        if (last_bit) state_n = FS_DONE;
      end
      FS_DONE: begin
        state_n = accept ? FS_RUN : FS_IDLE;
      end
      default: begin
        // Unused encoding: recover to IDLE.
        state_n = FS_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential datapath and control
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments here make every flop sample the values
  // from before the edge, so the shift registers, counter and borrow update
  // together regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FS_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n == FS_RUN);
      done_q  <= (state_n == FS_DONE);

      if (accept) begin
        a_sr  <= a;
        b_sr  <= b;
        br_q  <= bin;
        cnt_q <= '0;
      end else if (in_run) begin
        a_sr  <= a_sr >> 1;
        b_sr  <= b_sr >> 1;
        br_q  <= cell_bout;
        // After WIDTH shifts the first bit in (bit 0) has reached d_q[0].
        d_q   <= {cell_d, d_q[WIDTH-1:1]};
        cnt_q <= cnt_q + 1'b1;
        if (last_bit) begin
          bout_q <= cell_bout;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule : fs_serial

// File: tb/tb_fs_serial.sv
// -----------------------------------------------------------------------------
// tb_fs_serial
//
// Self-checking bench for fs_serial (WIDTH = 8). Stimulus pushes the expected
// {bout, d} into a queue when an operation is issued; a monitor pops and
// compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_fs_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [W:0] exp_q[$];   // {bout, d}

  always #5 clk = ~clk;

  fs_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma,
                                       input logic [W-1:0] mb,
                                       input logic mbin);
    return {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin : monitor
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result_d", 32'(d), 32'(e[W-1:0]));
          check("result_bout", 32'(bout), 32'(e[W]));
        end
      end
    end
  end

  // Watchdog so the run always ends on its own.
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Count edges from the current negedge until done is seen (bounded).
  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  // Issue one operation at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_bin, input logic [W:0] exp,
                        input string name);
    int n;
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    bin   = op_bin;
    exp_q.push_back(exp);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({name, "_latency"}, 32'(n), 32'd9);
    check({name, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  initial begin : stim
    int n;
    int dc0;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_d",    32'(d),    32'd0);
    check("reset_bout", 32'(bout), 32'd0);

    // Basic operation, then result hold in IDLE.
    run_op(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h1E}, "op_5a_3c");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("hold_d",    32'(d),    32'h1E);
    check("hold_bout", 32'(bout), 32'd0);
    check("hold_done", 32'(done), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);

    // Borrow-out cases and an all-ones boundary.
    run_op(8'h00, 8'h01, 1'b0, {1'b1, 8'hFF}, "op_00_01");
    run_op(8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF}, "op_ff_ff_1");
    run_op(8'hFF, 8'h00, 1'b0, {1'b0, 8'hFF}, "op_ff_00");
    run_op(8'h00, 8'h00, 1'b1, {1'b1, 8'hFF}, "op_00_00_1");
    @(posedge clk);
    @(negedge clk);

    // start pulsed 3 cycles into RUN with other operands is ignored.
    dc0   = done_cnt;
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    bin   = 1'b0;
    exp_q.push_back({1'b0, 8'h22});
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    bin   = 1'b1;
    @(posedge clk);
    n++;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ignore_latency", 32'(n), 32'd9);
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("ignore_single_done", 32'(done_cnt - dc0), 32'd1);

    // Reset during the 5th RUN cycle aborts the operation.
    dc0   = done_cnt;
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    bin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_d",    32'(d),    32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);

    // start held high: back-to-back results spaced WIDTH+1 cycles apart.
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    bin   = 1'b0;
    exp_q.push_back({1'b0, 8'h0F});
    exp_q.push_back({1'b0, 8'h00});
    @(posedge clk);
    n = 1;
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    wait_done(n);
    check("b2b_first_latency", 32'(n), 32'd9);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_again", 32'(busy), 32'd1);
    wait_done(n);
    check("b2b_spacing", 32'(n), 32'd9);
    @(posedge clk);
    @(negedge clk);

    // Random sweep against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom_range(1, 0));
      run_op(ra, rb, rbin, model(ra, rb, rbin), "rand");
    end

    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fs_serial
